// File: rtl/kpix_cmd_link.sv
// Host-side master for the KPIX serial command/readback link: serialises
// write/read/command frames on command_c and captures read responses on rdback_p.
module kpix_cmd_link #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        ext_clk,
    input  logic        reset_c,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_cmd,
    input  logic        req_write,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic        command_c,
    input  logic        rdback_p
);

    localparam logic [3:0] Marker  = 4'b1010;
    localparam logic [5:0] FullCnt = 6'd46;
    localparam logic [5:0] HdrCnt  = 6'd13;
    localparam logic [5:0] RxCnt   = 6'd45;
    localparam logic [9:0] TmoLast = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StWaitRsp,
        StRx,
        StDone
    } state_t;

    state_t      state_q;
    logic [46:0] tx_sr_q;
    logic [5:0]  bit_cnt_q;
    logic [9:0]  tmo_cnt_q;
    logic [45:0] rx_sr_q;
    logic [6:0]  addr_q;
    logic        is_read_q;
    logic        rdback_q;

    // Request frame, left-aligned so header-only frames share the full-frame shifter.
    logic        wr_bit;
    logic [12:0] hdr_body;
    logic [46:0] new_frame;

    always_comb begin
        wr_bit   = req_write & ~req_cmd;
        hdr_body = {Marker, req_cmd, wr_bit, req_addr};
        if (wr_bit) begin
            new_frame = {hdr_body, ~^hdr_body, req_wdata, ~^req_wdata};
        end else begin
            new_frame = {hdr_body, ~^hdr_body, 33'd0};
        end
    end

    // Completed response: 46 bits already shifted plus the bit now in the input flop.
    logic [46:0] rx_frame;
    logic        rx_bad;

    always_comb begin
        rx_frame = {rx_sr_q, rdback_q};
        rx_bad   = (rx_frame[46:43] != Marker)
                 | rx_frame[42]
                 | rx_frame[41]
                 | (rx_frame[40:34] != addr_q)
                 | ((^rx_frame[46:33]) == 1'b0)
                 | ((^rx_frame[32:0]) == 1'b0);
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    always_ff @(posedge ext_clk or negedge reset_c) begin
        if (!reset_c) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            rx_sr_q   <= '0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            rdback_q  <= 1'b0;
            command_c <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= '0;
        end else begin
            rdback_q <= rdback_p;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        is_read_q <= ~req_cmd & ~req_write;
                        command_c <= new_frame[46];
                        tx_sr_q   <= {new_frame[45:0], 1'b0};
                        bit_cnt_q <= wr_bit ? FullCnt : HdrCnt;
                        state_q   <= StTx;
                    end
                end
                StTx: begin
                    if (bit_cnt_q != 6'd0) begin
                        command_c <= tx_sr_q[46];
                        tx_sr_q   <= {tx_sr_q[45:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - 6'd1;
                    end else begin
                        command_c <= 1'b0;
                        if (is_read_q) begin
                            tmo_cnt_q <= '0;
                            state_q   <= StWaitRsp;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_err   <= 2'b00;
                            state_q   <= StDone;
                        end
                    end
                end
                StWaitRsp: begin
                    // The first sampled 1 is the leading marker bit.
                    if (rdback_q) begin
                        rx_sr_q   <= 46'd1;
                        bit_cnt_q <= RxCnt;
                        state_q   <= StRx;
                    end else if (tmo_cnt_q == TmoLast) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 2'b01;
                        state_q   <= StDone;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 10'd1;
                    end
                end
                StRx: begin
                    if (bit_cnt_q != 6'd0) begin
                        rx_sr_q   <= {rx_sr_q[44:0], rdback_q};
                        bit_cnt_q <= bit_cnt_q - 6'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx_frame[32:1];
                        rsp_err   <= {rx_bad, 1'b0};
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    command_c <= 1'b0;
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kpix_cmd_link.sv
// Self-checking bench for kpix_cmd_link: directed table, randomized transactions
// against a bit-list frame model, back-to-back and mid-frame reset sequences.
module tb_kpix_cmd_link;

    localparam int unsigned TMO = 255;

    logic        ext_clk   = 1'b0;
    logic        reset_c   = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_cmd   = 1'b0;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        rdback_p  = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;
    logic        command_c;

    int n_vec = 0;
    int n_bad = 0;

    always #5 ext_clk = ~ext_clk;

    kpix_cmd_link #(.TIMEOUT(TMO)) dut (
        .ext_clk   (ext_clk),
        .reset_c   (reset_c),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .command_c (command_c),
        .rdback_p  (rdback_p)
    );

    typedef struct {
        bit          cmd;
        bit          wr;
        bit [6:0]    addr;
        bit [31:0]   wdata;
        logic [46:0] exp_frame;  // left-aligned, first bit at [46]
        int          exp_len;
        int          rmode;      // 1: KPIX answers with rsp_frame, 0: silent
        logic [46:0] rsp_frame;
        int          dly;
        bit [31:0]   exp_data;
        bit [1:0]    exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Frame built as an ordered bit list straight from the field/parity rules.
    function automatic logic [46:0] model_frame(input bit cmd, input bit wr, input bit [6:0] addr,
                                                input bit [31:0] data, input bit full);
        bit q[$];
        int ones;
        logic [46:0] f;
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0);
        q.push_back(cmd);
        q.push_back(wr);
        for (int i = 6; i >= 0; i--) q.push_back(addr[i]);
        ones = 0;
        foreach (q[i]) ones += int'(q[i]);
        q.push_back(ones % 2 == 0);
        if (full) begin
            ones = 0;
            for (int i = 31; i >= 0; i--) begin
                q.push_back(data[i]);
                ones += int'(data[i]);
            end
            q.push_back(ones % 2 == 0);
        end
        f = '0;
        foreach (q[i]) f[46-i] = q[i];
        return f;
    endfunction

    function automatic bit [31:0] model_rsp_data(input logic [46:0] f);
        bit [31:0] d = '0;
        for (int i = 0; i < 32; i++) d[31-i] = f[46-14-i];
        return d;
    endfunction

    function automatic bit [1:0] model_rsp_err(input logic [46:0] f, input bit [6:0] addr);
        int hones = 0;
        int dones = 0;
        bit bad = 0;
        bit b[47];
        for (int i = 0; i < 47; i++) b[i] = f[46-i];
        if (!(b[0] == 1 && b[1] == 0 && b[2] == 1 && b[3] == 0)) bad = 1;
        if (b[4] != 0 || b[5] != 0) bad = 1;
        for (int i = 0; i < 7; i++) if (b[6+i] != addr[6-i]) bad = 1;
        for (int i = 0; i < 14; i++) hones += int'(b[i]);
        for (int i = 14; i < 47; i++) dones += int'(b[i]);
        if (hones % 2 == 0 || dones % 2 == 0) bad = 1;
        return {bad, 1'b0};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [46:0] obs;
        bit ready_seen, stray, early, is_read;
        int n, exp_wait;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge ext_clk);
            n++;
        end
        if (!req_ready) begin
            chk({tag, " ready wait"}, 0, 1);
            return;
        end
        req_cmd = v.cmd; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        @(posedge ext_clk);
        #1 req_valid = 1'b0;
        obs = '0; ready_seen = 0; stray = 0; early = 0;
        for (int k = 0; k < v.exp_len; k++) begin
            @(negedge ext_clk);
            obs[46-k] = command_c;
            if (req_ready) ready_seen = 1;
        end
        chk({tag, " frame"}, obs, v.exp_frame);
        chk({tag, " req_ready low during frame"}, ready_seen, 0);
        is_read = !v.cmd && !v.wr;
        exp_wait = 1;
        if (is_read && v.rmode == 1) begin
            for (int d = 0; d < v.dly; d++) begin
                @(negedge ext_clk);
                if (command_c) stray = 1;
                if (rsp_valid) early = 1;
            end
            for (int i = 0; i < 47; i++) begin
                rdback_p = v.rsp_frame[46-i];
                @(negedge ext_clk);
                if (command_c) stray = 1;
                if (rsp_valid) early = 1;
            end
            rdback_p = 1'b0;
            chk({tag, " early rsp_valid"}, early, 0);
        end else if (is_read) begin
            exp_wait = TMO + 1;
        end
        n = 0;
        do begin
            @(negedge ext_clk);
            n++;
            if (command_c) stray = 1;
        end while (!rsp_valid && n < 2000);
        chk({tag, " rsp latency"}, n, exp_wait);
        chk({tag, " command_c idle after frame"}, stray, 0);
        chk({tag, " rsp_data"}, rsp_data, v.exp_data);
        chk({tag, " rsp_err"}, rsp_err, v.exp_err);
        @(negedge ext_clk);
        chk({tag, " pulse end {valid,ready,busy}"}, {rsp_valid, req_ready, busy}, 3'b010);
        chk({tag, " rsp hold"}, {rsp_data, rsp_err}, {v.exp_data, v.exp_err});
    endtask

    initial begin
        vec_t v;
        logic [46:0] f;
        logic [47:0] obs_c, obs_v, exp_c, exp_v;
        bit seen;
        int kind, j;

        // Expected frames written out by hand from the field/parity rules.
        tbl[0] = '{0, 1, 7'h01, 32'h1, {14'b10100100000011, 33'h2}, 47, 0, 47'h0, 0, 32'h0, 2'b00};
        tbl[1] = '{1, 0, 7'h02, 32'h0, {14'b10101000000101, 33'h0}, 14, 0, 47'h0, 0, 32'h0, 2'b00};
        tbl[2] = '{0, 0, 7'h05, 32'h0, {14'b10100000001011, 33'h0}, 14, 1,
                   {14'b10100000001011, 32'hDEADBEEF, 1'b1}, 10, 32'hDEADBEEF, 2'b00};
        tbl[3] = '{0, 0, 7'h05, 32'h0, {14'b10100000001011, 33'h0}, 14, 1,
                   {14'b10100000001011, 32'hDEADBEEE, 1'b1}, 10, 32'hDEADBEEE, 2'b10};
        tbl[4] = '{0, 0, 7'h05, 32'h0, {14'b10100000001011, 33'h0}, 14, 1,
                   {14'b10100000001101, 32'hDEADBEEF, 1'b1}, 10, 32'hDEADBEEF, 2'b10};
        tbl[5] = '{0, 0, 7'h33, 32'h0, {14'b10100001100111, 33'h0}, 14, 0, 47'h0, 0, 32'h0, 2'b01};
        tbl[6] = '{1, 1, 7'h7F, 32'hFFFFFFFF, {14'b10101011111111, 33'h0}, 14, 0, 47'h0, 0,
                   32'h0, 2'b00};
        tbl[7] = '{0, 1, 7'h7F, 32'hFFFFFFFF, {14'b10100111111111, 32'hFFFFFFFF, 1'b1}, 47, 0,
                   47'h0, 0, 32'h0, 2'b00};

        repeat (3) @(negedge ext_clk);
        chk("reset outputs", {command_c, rsp_valid, rsp_err, rsp_data, busy}, 0);
        reset_c = 1'b1;
        @(negedge ext_clk);
        chk("ready after reset", {req_ready, busy}, 2'b10);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 3);
            v.addr = 7'($urandom);
            v.wdata = $urandom;
            v.cmd = (kind == 1);
            v.wr = (kind == 0) ? 1'b1 : (kind == 1) ? 1'($urandom) : 1'b0;
            v.exp_frame = model_frame(v.cmd, v.wr && !v.cmd, v.addr, v.wdata, v.wr && !v.cmd);
            v.exp_len = (v.wr && !v.cmd) ? 47 : 14;
            v.rmode = (kind >= 2) ? 1 : 0;
            v.dly = $urandom_range(1, 30);
            v.rsp_frame = model_frame(0, 0, v.addr, $urandom, 1);
            if (kind == 3) begin
                if ($urandom_range(0, 1) == 1) begin
                    j = $urandom_range(1, 46);
                    v.rsp_frame[46-j] = ~v.rsp_frame[46-j];
                end else begin
                    v.rsp_frame = model_frame(0, 0, v.addr ^ (7'd1 << $urandom_range(0, 6)),
                                              model_rsp_data(v.rsp_frame), 1);
                end
            end
            v.exp_data = (kind >= 2) ? model_rsp_data(v.rsp_frame) : 32'h0;
            v.exp_err = (kind >= 2) ? model_rsp_err(v.rsp_frame, v.addr) : 2'b00;
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // Held req_valid: commands repeat every L+2 cycles, two idle-low cycles between.
        f = model_frame(1, 0, 7'h2A, 32'h0, 0);
        req_cmd = 1'b1; req_write = 1'b0; req_addr = 7'h2A; req_wdata = '0;
        req_valid = 1'b1;
        for (int k = 0; k < 48; k++) begin
            @(negedge ext_clk);
            obs_c[47-k] = command_c;
            obs_v[47-k] = rsp_valid;
            exp_c[47-k] = ((k % 16) < 14) ? f[46-(k % 16)] : 1'b0;
            exp_v[47-k] = ((k % 16) == 14);
        end
        req_valid = 1'b0;
        chk("b2b command_c stream", obs_c, exp_c);
        chk("b2b rsp_valid stream", obs_v, exp_v);
        @(negedge ext_clk);
        chk("b2b idle after", {busy, req_ready}, 2'b01);

        // Reset asserted while bit 20 of a write frame is on the line.
        req_cmd = 1'b0; req_write = 1'b1; req_addr = 7'h11; req_wdata = 32'hA5A5_0F0F;
        req_valid = 1'b1;
        @(posedge ext_clk);
        #1 req_valid = 1'b0;
        repeat (21) @(negedge ext_clk);
        reset_c = 1'b0;
        #1;
        chk("reset abort outputs", {command_c, busy, rsp_valid, rsp_err, rsp_data}, 0);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge ext_clk);
            if (k == 3) reset_c = 1'b1;
            if (rsp_valid || command_c) seen = 1;
        end
        chk("no rsp_valid after abort", seen, 0);
        chk("ready after abort", {req_ready, busy}, 2'b10);
        run_vec(tbl[0], "post-reset write");
        run_vec(tbl[2], "post-reset read");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
